// File: rtl/exp_pulse_gen.sv
// Synthetic detector-pulse source: linear rise then single-pole exponential decay on a baseline.
// Define EXP_PULSE_GEN_NOISE_EN to add a small LFSR dither (-4..+3 LSB) to every output sample.
module exp_pulse_gen #(
  parameter int DATA_W      = 12,
  parameter int AMP_W       = 12,
  parameter int FRAC_W      = 8,
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 4,
  parameter int BASELINE    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AMP_W-1:0]  amplitude,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] adc_data
);

  localparam int ACC_W  = AMP_W + FRAC_W + 1;
  localparam int STEP_W = AMP_W + FRAC_W;
  localparam int CNT_W  = RISE_SHIFT + 1;
  localparam int INT_W  = ACC_W - FRAC_W;
  localparam int SUM_W  = ((INT_W > DATA_W) ? INT_W : DATA_W) + 2;

  localparam logic [CNT_W-1:0] LAST_ADD = CNT_W'((1 << RISE_SHIFT) - 1);
  localparam logic [SUM_W-1:0] DATA_MAX = SUM_W'((1 << DATA_W) - 1);
  localparam logic [SUM_W-1:0] BASE     = SUM_W'(BASELINE);

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    rise_cnt_q, rise_cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   adc_q, adc_d;

  logic                accept;
  logic [STEP_W-1:0]   step_new;
  logic [ACC_W:0]      acc_sum;
  logic [ACC_W-1:0]    acc_sat;
  logic [ACC_W-1:0]    acc_dec;
  logic [SUM_W-1:0]    sample;

  assign accept   = start && ready_q;
  assign step_new = {amplitude, {FRAC_W{1'b0}}} >> RISE_SHIFT;
  assign acc_sum  = {1'b0, acc_q} + (ACC_W + 1)'(step_q);
  assign acc_sat  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  assign acc_dec  = acc_q - (acc_q >> DECAY_SHIFT);
  assign sample   = SUM_W'(acc_q >> FRAC_W) + BASE;

`ifdef EXP_PULSE_GEN_NOISE_EN
  logic [15:0]  lfsr_q, lfsr_d;
  logic [SUM_W:0] noisy;

  // Galois form, taps 16,14,13,11; low three bits read as a signed -4..+3 dither.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign noisy  = {1'b0, sample} + {{(SUM_W - 2){lfsr_q[2]}}, lfsr_q[2:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    rise_cnt_d = rise_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (accept) begin
          step_d     = step_new;
          rise_cnt_d = '0;
          state_d    = RISE;
        end
      end
      RISE: begin
        acc_d      = acc_sat;
        rise_cnt_d = rise_cnt_q + 1'b1;
        if (rise_cnt_q == LAST_ADD) state_d = DECAY;
      end
      DECAY: begin
        // A new request freezes the tail for one cycle; the ramp then stacks on top of it.
        if (accept) begin
          step_d     = step_new;
          rise_cnt_d = '0;
          state_d    = RISE;
        end else if (acc_dec[ACC_W-1:FRAC_W] == '0) begin
          acc_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          acc_d = acc_dec;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DECAY);
    busy_d  = (state_d == RISE) || (state_d == DECAY);

`ifdef EXP_PULSE_GEN_NOISE_EN
    if (noisy[SUM_W])                   adc_d = '0;
    else if (noisy[SUM_W-1:0] > DATA_MAX) adc_d = {DATA_W{1'b1}};
    else                                adc_d = noisy[DATA_W-1:0];
`else
    if (sample > DATA_MAX) adc_d = {DATA_W{1'b1}};
    else                   adc_d = sample[DATA_W-1:0];
`endif
  end

  // NOTE: state flops use non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      rise_cnt_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      adc_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      rise_cnt_q <= rise_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      adc_q      <= adc_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign adc_data = adc_q;

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Bench for exp_pulse_gen: integer-arithmetic pulse model checked every cycle, plus directed
// pulse traces pinned to hand-computed sample values.
module tb_exp_pulse_gen;

  localparam int     DATA_W      = 12;
  localparam int     AMP_W       = 12;
  localparam int     FRAC_W      = 8;
  localparam int     RISE_SHIFT  = 2;
  localparam int     DECAY_SHIFT = 4;
  localparam int     BASELINE    = 100;
  localparam longint ACC_MAX     = (longint'(1) << (AMP_W + FRAC_W + 1)) - 1;
  localparam longint DATA_MAX    = (longint'(1) << DATA_W) - 1;
  localparam int     TR_MAX      = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [AMP_W-1:0]  amplitude = '0;
  logic              ready, busy, done;
  logic [DATA_W-1:0] adc_data;

  exp_pulse_gen #(
    .DATA_W(DATA_W), .AMP_W(AMP_W), .FRAC_W(FRAC_W),
    .RISE_SHIFT(RISE_SHIFT), .DECAY_SHIFT(DECAY_SHIFT), .BASELINE(BASELINE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
    .ready(ready), .busy(busy), .done(done), .adc_data(adc_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Pulse model: remaining ramp adds, a decaying flag, and the accumulator as a plain integer.
  typedef struct {
    longint acc;
    longint step;
    int     adds_left;
    bit     decaying;
    longint adc;
    bit     ready;
    bit     busy;
    bit     done;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, logic s, logic [AMP_W-1:0] a);
    model_t n;
    longint t;
    n      = c;
    t      = BASELINE + (c.acc >> FRAC_W);
    n.adc  = (t > DATA_MAX) ? DATA_MAX : t;
    n.done = 1'b0;
    if (s && c.ready) begin
      n.step      = (longint'(a) << FRAC_W) >> RISE_SHIFT;
      n.adds_left = 1 << RISE_SHIFT;
      n.decaying  = 1'b0;
    end else if (c.adds_left > 0) begin
      t           = c.acc + c.step;
      n.acc       = (t > ACC_MAX) ? ACC_MAX : t;
      n.adds_left = c.adds_left - 1;
      if (n.adds_left == 0) n.decaying = 1'b1;
    end else if (c.decaying) begin
      t = c.acc - (c.acc >> DECAY_SHIFT);
      if ((t >> FRAC_W) == 0) begin
        n.acc      = 0;
        n.decaying = 1'b0;
        n.done     = 1'b1;
      end else begin
        n.acc = t;
      end
    end
    n.ready = (n.adds_left == 0);
    n.busy  = (n.adds_left > 0) || n.decaying;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '{default: 0};
    else        m <= model_step(m, start, amplitude);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("adc_data", adc_data, m.adc);
      check("ready", ready, m.ready);
      check("busy", busy, m.busy);
      check("done", done, m.done);
    end
  end

  int tr_adc [TR_MAX];
  bit tr_rdy [TR_MAX];
  bit tr_done[TR_MAX];
  int tr_len, done_cnt;
  int ref_adc[TR_MAX];
  int ref_len;

  // Handshake at edge T0; tr_*[k] is sampled after edge Tk. A second request (if k2 > 0)
  // is presented so that edge Tk2 samples it. Stops one sample after done.
  task automatic run_pulse(input int amp, input int k2, input int amp2);
    @(negedge clk);
    start     = 1'b1;
    amplitude = AMP_W'(amp);
    tr_len    = 0;
    done_cnt  = 0;
    for (int k = 0; k < TR_MAX; k++) begin
      @(negedge clk);
      start      = 1'b0;
      tr_adc[k]  = int'(adc_data);
      tr_rdy[k]  = ready;
      tr_done[k] = done;
      if (done) done_cnt++;
      tr_len = k + 1;
      if (k2 > 0 && k + 1 == k2) begin
        start     = 1'b1;
        amplitude = AMP_W'(amp2);
      end
      if (k > 0 && tr_done[k-1]) break;
    end
    start = 1'b0;
    check("pulse_done_count", done_cnt, 1);
  endtask

  function automatic int count_rises(int from, int to);
    int c = 0;
    for (int k = from; k < to; k++) if (tr_adc[k+1] > tr_adc[k]) c++;
    return c;
  endfunction

  function automatic int count_falls(int from, int to);
    int c = 0;
    for (int k = from; k < to; k++) if (tr_adc[k+1] < tr_adc[k]) c++;
    return c;
  endfunction

  function automatic int trace_max();
    int mx = 0;
    for (int k = 0; k < tr_len; k++) if (tr_adc[k] > mx) mx = tr_adc[k];
    return mx;
  endfunction

  function automatic int ref_diffs();
    int c = 0;
    for (int k = 0; k < tr_len && k < ref_len; k++) if (tr_adc[k] != ref_adc[k]) c++;
    return c;
  endfunction

  initial begin
    int busy_wait;
    int rdy_hi;

    // Reset, then idle.
    reset = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_adc", adc_data, 0);
    check("rst_ready", ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_adc", adc_data, BASELINE);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Single pulse, amplitude 1000.
    run_pulse(1000, 0, 0);
    check("single_T2", tr_adc[2], 350);
    check("single_T4", tr_adc[4], 850);
    check("single_peak_T5", tr_adc[5], 1100);
    check("single_T6", tr_adc[6], 1037);
    check("single_T7", tr_adc[7], 978);
    rdy_hi = 0;
    for (int k = 0; k < 4; k++) if (tr_rdy[k]) rdy_hi++;
    check("rise_ready_low", rdy_hi, 0);
    check("decay_ready_T4", tr_rdy[4], 1);
    check("single_monotonic", count_rises(5, tr_len - 1), 0);
    check("single_end_baseline", tr_adc[tr_len-1], BASELINE);
    ref_len = tr_len;
    for (int k = 0; k < TR_MAX; k++) ref_adc[k] = tr_adc[k];

    // Request during RISE is ignored.
    run_pulse(1000, 2, 500);
    check("rise_req_peak", tr_adc[5], 1100);
    check("rise_req_max", trace_max(), 1100);
    check("rise_req_same_trace", ref_diffs(), 0);
    check("rise_req_len", tr_len, ref_len);

    // Pile-up on the tail at T10.
    run_pulse(1000, 10, 1000);
    check("pileup_tail_T10", tr_adc[10], 824);
    check("pileup_peak_T15", tr_adc[15], 1824);
    check("pileup_step_ok", ((tr_adc[15] - tr_adc[10] - 1000) >= -1 &&
                             (tr_adc[15] - tr_adc[10] - 1000) <= 1) ? 1 : 0, 1);

    // Saturation: second 4000 request on the first DECAY cycle.
    run_pulse(4000, 5, 4000);
    check("sat_T5", tr_adc[5], 4095);
    check("sat_T10", tr_adc[10], 4095);
    check("sat_no_wrap", count_falls(0, 10), 0);
    check("sat_max", trace_max(), 4095);

    // Zero amplitude: full rise, then done on the first DECAY edge.
    run_pulse(0, 0, 0);
    check("zero_done_T5", tr_done[5], 1);
    check("zero_adc_T5", tr_adc[5], BASELINE);
    check("zero_len", tr_len, 7);

    // Asynchronous reset in the middle of a decay.
    @(negedge clk);
    start = 1'b1;
    amplitude = AMP_W'(1000);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_adc", adc_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_pulse(1000, 0, 0);
    check("post_rst_same_trace", ref_diffs(), 0);
    check("post_rst_len", tr_len, ref_len);

    // Random requests with frequent pile-ups, checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) amplitude = AMP_W'(4095 - $urandom_range(0, 200));
      else                           amplitude = AMP_W'($urandom_range(0, 4095));
    end
    @(negedge clk);
    start = 1'b0;
    busy_wait = 0;
    while (busy && busy_wait < 500) begin
      @(negedge clk);
      busy_wait++;
    end
    check("drain_idle", busy, 0);
    @(negedge clk);
    check("drain_baseline", adc_data, BASELINE);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
